uart_tx_result: RTL and testbench
=================================

Name: uart_tx_result

Overview:
- UART transmitter at the output end of the CNN pipeline.
- Accepts the classified-digit byte from the final fully-connected layer through a trmt/tx_data request and serialises it on the board TX pin, 8N1 by default.
- Pulses tx_done when the frame completes; this releases the layer to clear its argmax state and accept the next image.

Parameters:
- BAUD_DIV, 434, clocks per bit (50 MHz / 115200); legal range 2..65535.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- trmt  input  1  transmit request; a level held high by the producer until tx_done.
- tx_data  input  8  byte to send; valid while trmt is high.
- TX  output  1  serial line; idle high.
- tx_done  output  1  one-cycle pulse at the end of the frame.
- busy  output  1  high from accept through the final stop bit.

Behaviour:
- Reset: clk is the clock; rst_n is the reset, asynchronous and active-low. Reset values: TX=1, tx_done=0, busy=0, state=IDLE, baud counter=0, bit counter=0, shift register=0xFF, trmt_q=0.
- Request detection: trmt is a level, so a frame starts only on the rising edge of trmt. The rising edge is trmt=1 and trmt_q=0, where trmt_q is trmt registered every cycle.
  - If trmt is already high when reset deasserts, that counts as an edge.
  - The producer drops trmt the cycle after tx_done. A trmt still high in the tx_done cycle must not start a second frame.
- Accept: happens in IDLE on a rising edge of trmt.
  - tx_data is latched into the shift register.
  - busy goes to 1 and the state moves to START.
  - TX goes low on the next clock edge, giving a 1-cycle accept-to-start-bit latency.
- Rising edges of trmt while busy=1 are ignored and not queued. tx_data changes after accept have no effect.
- State machine:
  - IDLE: TX=1; moves to START on accept.
  - START: TX=0 for BAUD_DIV clocks, then DATA.
  - DATA: 8 bits, LSB first, each held BAUD_DIV clocks. The shift register shifts right at each bit boundary. After bit 7 the state goes to STOP (or PARITY, see Optional Feature).
  - STOP: TX=1 for STOP_BITS*BAUD_DIV clocks. On the final clock of the stop period, tx_done=1 for exactly that cycle, then IDLE with busy=0.
- Baud counter:
  - Counts 0..BAUD_DIV-1; the bit boundary is at count BAUD_DIV-1.
  - Cleared on accept and at every bit boundary.
  - Holds 0 in IDLE.
- Bit counter: 0..7 in DATA; 0..STOP_BITS-1 in STOP. Cleared on every state change.
- Frame timing: from the first TX=0 cycle to the tx_done cycle is (10+STOP_BITS-1)*BAUD_DIV clocks inclusive.
- Back-to-back frames: a rising edge of trmt in the cycle after tx_done is accepted (IDLE has been reached). The minimum gap between frames is therefore the producer's own trmt low time.
- Reset mid-frame: TX returns to 1 immediately (asynchronously). No tx_done is produced. The interrupted frame is not resumed.
- Outputs are registered: TX, tx_done and busy all come from flops, with no combinational path from inputs.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - TX is held for BAUD_DIV clocks at the even-parity bit, the XOR of the 8 latched data bits.
  - The frame becomes 8E1 (or 8E2) and is BAUD_DIV clocks longer.
- Undefined: no PARITY state exists; DATA goes directly to STOP (8N1/8N2).

Test Plan (BAUD_DIV=4, STOP_BITS=1 unless stated):
- Basic frame, tx_data=0x07, trmt rising edge:
  - TX is low from the next cycle for 4 clocks.
  - Then the 4-clock bit pattern is 1,1,1,0,0,0,0,0, then stop 1.
  - tx_done pulses once, 40 clocks after the first low TX cycle (cycle 40 inclusive). busy falls with it.
- Level hold: trmt is held high for 20 clocks after tx_done.
  - No second frame; TX stays 1 and busy stays 0.
  - A trmt low-then-high afterwards starts a new frame with 0x03 correctly.
- Request while busy: a trmt 0→1 edge at clock 15 of a 0xA5 frame.
  - Ignored; exactly one frame is emitted (LSB-first bits 1,0,1,0,0,1,0,1) and one tx_done.
- Reset mid-frame: rst_n low during data bit 3 of 0xFF.
  - TX=1, busy=0, tx_done=0 immediately.
  - After release, with trmt high, a fresh frame starts from the start bit.
- STOP_BITS=2, tx_data=0x00: the stop period is 8 clocks of TX=1 and tx_done lands at clock 44.
- UART_TX_PARITY_EN defined: 0x07 gives parity bit 1 and 0x03 gives parity bit 0; tx_done lands at clock 44 (BAUD_DIV=4, 1 stop bit).

Source files
------------

// File: rtl/uart_tx_result_if.sv
// Producer-to-transmitter link for uart_tx_result: level request, data byte,
// serial line and completion/busy status.
interface uart_tx_result_if;
    logic       trmt;
    logic [7:0] tx_data;
    logic       TX;
    logic       tx_done;
    logic       busy;

    modport master (output trmt, output tx_data, input TX, input tx_done, input busy);
    modport slave  (input trmt, input tx_data, output TX, output tx_done, output busy);
endinterface

// File: rtl/uart_tx_result.sv
// UART transmitter for the classified-digit byte: 8N1/8N2 frames by default,
// 8E1/8E2 when UART_TX_PARITY_EN is defined. All outputs are registered.
module uart_tx_result #(
    parameter int BAUD_DIV  = 434,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_result_if.slave  bus
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        trmt_q;
    logic        tx_q, tx_d;
    logic        tx_done_q, tx_done_d;
    logic        busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    logic accept;
    logic boundary;

    // trmt is a level; only its rising edge requests a frame
    assign accept   = (state_q == ST_IDLE) && bus.trmt && !trmt_q;
    assign boundary = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = boundary ? 16'd0 : baud_q + 16'd1;
        bit_d    = bit_q;
        shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                baud_d = 16'd0;
                if (accept) begin
                    state_d  = ST_START;
                    shift_d  = bus.tx_data;
                    bit_d    = 3'd0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^bus.tx_data;
`endif
                end
            end
            ST_START: begin
                if (boundary) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                end
            end
            ST_DATA: begin
                if (boundary) begin
                    shift_d = {1'b1, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (boundary) begin
                    state_d = ST_STOP;
                    bit_d   = 3'd0;
                end
            end
`endif
            ST_STOP: begin
                if (boundary) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = 16'd0;
                bit_d   = 3'd0;
            end
        endcase
    end

    // Outputs are decoded from next state so the flops present them in the same cycle
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:   tx_d = 1'b1;
        endcase
        busy_d    = (state_d != ST_IDLE);
        tx_done_d = (state_d == ST_STOP) && (baud_d == BAUD_LAST) && (bit_d == STOP_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            baud_q    <= 16'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'hFF;
            trmt_q    <= 1'b0;
            tx_q      <= 1'b1;
            tx_done_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            trmt_q    <= bus.trmt;
            tx_q      <= tx_d;
            tx_done_q <= tx_done_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign bus.TX      = tx_q;
    assign bus.tx_done = tx_done_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_result.sv
// Directed bench for uart_tx_result at BAUD_DIV=4: one instance with one stop
// bit, one with two. Expectations follow UART_TX_PARITY_EN when defined.
module tb_uart_tx_result;

    localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR   = 1'b1;
    localparam int DONE1 = 44;
    localparam int DONE2 = 48;
`else
    localparam bit PAR   = 1'b0;
    localparam int DONE1 = 40;
    localparam int DONE2 = 44;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_result_if if1 ();
    uart_tx_result_if if2 ();

    uart_tx_result #(.BAUD_DIV(BD), .STOP_BITS(1)) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if1.slave)
    );

    uart_tx_result #(.BAUD_DIV(BD), .STOP_BITS(2)) dut2 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (if2.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       par;
        int         done_at;
        int         hold;
        int         poke;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input int sel, input logic t, input logic [7:0] d);
        if (sel == 2) begin
            if2.trmt    = t;
            if2.tx_data = d;
        end else begin
            if1.trmt    = t;
            if1.tx_data = d;
        end
    endtask

    function automatic logic [2:0] outs(input int sel);
        if (sel == 2) return {if2.TX, if2.tx_done, if2.busy};
        return {if1.TX, if1.tx_done, if1.busy};
    endfunction

    // Raises trmt (unless already high), checks every cycle of the frame,
    // then drops trmt (or holds it) and checks the line stays idle.
    task automatic run_frame(input int sel, input logic [7:0] d, input logic par,
                             input int done_at, input int hold, input int poke,
                             input bit pre);
        logic [2:0] o;
        logic       exp_tx;
        int         idx;
        int         n_idle;
        if (!pre) begin
            @(posedge clk);
            #1 drive(sel, 1'b1, d);
        end
        @(posedge clk);
        for (int c = 1; c <= done_at; c++) begin
            @(negedge clk);
            o   = outs(sel);
            idx = (c - 1) / BD;
            if (idx == 0)                 exp_tx = 1'b0;
            else if (idx <= 8)            exp_tx = d[3'(idx - 1)];
            else if (PAR && idx == 9)     exp_tx = par;
            else                          exp_tx = 1'b1;
            chk("tx_line", {31'd0, o[2]}, {31'd0, exp_tx});
            chk("tx_done", {31'd0, o[1]}, (c == done_at) ? 32'd1 : 32'd0);
            chk("busy",    {31'd0, o[0]}, 32'd1);
            if (c == poke - 2) drive(sel, 1'b0, 8'h00);
            if (c == poke)     drive(sel, 1'b1, ~d);
        end
        @(posedge clk);
        #1;
        if (hold == 0) drive(sel, 1'b0, d);
        n_idle = (hold > 0) ? hold : 3;
        for (int k = 0; k < n_idle; k++) begin
            @(negedge clk);
            o = outs(sel);
            chk("idle_tx",   {31'd0, o[2]}, 32'd1);
            chk("idle_done", {31'd0, o[1]}, 32'd0);
            chk("idle_busy", {31'd0, o[0]}, 32'd0);
        end
        if (hold > 0) begin
            @(posedge clk);
            #1 drive(sel, 1'b0, d);
        end
        $display("frame sel=%0d data=%02h done_at=%0d hold=%0d poke=%0d", sel, d, done_at, hold, poke);
    endtask

    initial begin
        logic [2:0] o;
        // sel, data, parity, tx_done clock, trmt hold after done, re-edge clock
        vecs[0] = '{1, 8'h07, 1'b1, DONE1, 20, -10};
        vecs[1] = '{1, 8'h03, 1'b0, DONE1,  0, -10};
        vecs[2] = '{1, 8'hA5, 1'b0, DONE1,  0,  15};
        vecs[3] = '{2, 8'h00, 1'b0, DONE2,  0, -10};
        vecs[4] = '{1, 8'h80, 1'b1, DONE1,  0, -10};

        drive(1, 1'b0, 8'h00);
        drive(2, 1'b0, 8'h00);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx1",   {31'd0, if1.TX},      32'd1);
        chk("rst_done1", {31'd0, if1.tx_done}, 32'd0);
        chk("rst_busy1", {31'd0, if1.busy},    32'd0);
        chk("rst_tx2",   {31'd0, if2.TX},      32'd1);
        chk("rst_busy2", {31'd0, if2.busy},    32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_tx1",   {31'd0, if1.TX},   32'd1);
        chk("post_rst_busy1", {31'd0, if1.busy}, 32'd0);

        for (int i = 0; i < 5; i++)
            run_frame(vecs[i].sel, vecs[i].data, vecs[i].par, vecs[i].done_at,
                      vecs[i].hold, vecs[i].poke, 1'b0);

        // Reset in the middle of data bit 3 of 0xFF, trmt left high
        @(posedge clk);
        #1 drive(1, 1'b1, 8'hFF);
        @(posedge clk);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 18) chk("mid_frame_tx", {31'd0, if1.TX}, 32'd1);
        end
        chk("mid_frame_busy", {31'd0, if1.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        o = outs(1);
        chk("async_rst_outs", {29'd0, o}, 32'b100);
        @(negedge clk);
        o = outs(1);
        chk("held_rst_outs", {29'd0, o}, 32'b100);
        rst_n = 1'b1;
        $display("reset mid-frame applied and released with trmt high");
        run_frame(1, 8'hFF, 1'b0, DONE1, 0, -10, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
